// File: rtl/mshr_alloc_arbiter_pkg.sv
// Shared data-cache sizing defaults used by the MSHR allocation/arbitration slice.
package mshr_alloc_arbiter_pkg;
    localparam int DC_NMSHR = 4;
    localparam int DC_IDX_W = 6;
    localparam int DC_TAG_W = 20;
endpackage

// File: rtl/mshr_alloc_arbiter_rr_lock.sv
// Round-robin arbiter that holds its winner until the shared port accepts,
// so a ready/valid handshake never sees the selection change mid-transfer.
module rr_lock_arbiter #(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          out_ready,
    output logic [N-1:0]  gnt,
    output logic          valid,
    output logic [SW-1:0] sel,
    output logic          lock
);
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] lock_sel_q;
    logic          lock_q;
    logic [SW-1:0] rr_sel;
    logic          hold;

    always_comb begin
        rr_sel = '0;
        // Walk from the far end so the requester closest to ptr_q is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[ptr_q + SW'(k)]) rr_sel = ptr_q + SW'(k);
        end
        hold  = lock_q & req[lock_sel_q];
        sel   = hold ? lock_sel_q : rr_sel;
        valid = |req;
        lock  = hold;
        gnt   = '0;
        if (valid && out_ready) gnt[sel] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_sel_q <= '0;
            lock_q     <= 1'b0;
        end else if (valid) begin
            if (out_ready) begin
                lock_q <= 1'b0;
                ptr_q  <= sel + SW'(1);
            end else begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end
        end else begin
            lock_q <= 1'b0;
        end
    end

    a_lock_dropped: assert property (@(posedge clock) disable iff (reset)
        !(lock_q && !req[lock_sel_q]));
    a_gnt_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(gnt));
endmodule

// File: rtl/mshr_alloc_arbiter.sv
// Steers a new miss to a merging MSHR (secondary) or a free one (primary), and
// round-robin shares the meta-read and acquire ports among the MSHRs.
module mshr_alloc_arbiter
    import mshr_alloc_arbiter_pkg::*;
#(
    parameter int NMSHR = DC_NMSHR,
    parameter int IDX_W = DC_IDX_W,
    parameter int TAG_W = DC_TAG_W,
    localparam int PW = $clog2(NMSHR)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       req_idx,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic [NMSHR-1:0]       mshr_valid,
    input  logic [NMSHR*IDX_W-1:0] mshr_idx,
    input  logic [NMSHR*TAG_W-1:0] mshr_tag,
    input  logic [NMSHR-1:0]       mshr_pri_rdy,
    input  logic [NMSHR-1:0]       mshr_sec_rdy,
    output logic [NMSHR-1:0]       pri_val,
    output logic [NMSHR-1:0]       sec_val,
    input  logic [NMSHR-1:0]       mr_req,
    output logic [NMSHR-1:0]       mr_gnt,
    output logic                   meta_read_valid,
    input  logic                   meta_read_ready,
    input  logic [NMSHR-1:0]       acq_req,
    output logic [NMSHR-1:0]       acq_gnt,
    output logic                   acquire_valid,
    input  logic                   acquire_ready,
    output logic [PW-1:0]          acq_sel,
    output logic                   alloc_full
);
    logic [NMSHR-1:0] m, c;
    logic             aq_v;
    logic [IDX_W-1:0] aq_idx;
    logic [TAG_W-1:0] aq_tag;
    logic             aq_match, aq_conf, stall, hit, pri_found, pri_fire;
    logic [PW-1:0]    hit_sel, pri_sel, alloc_ptr;
    logic             mr_lock, acq_lock;
    logic [PW-1:0]    mr_sel;

    always_comb begin
        m = '0;
        c = '0;
        for (int i = 0; i < NMSHR; i++) begin
            if (mshr_valid[i] && mshr_idx[i*IDX_W +: IDX_W] == req_idx) begin
                if (mshr_tag[i*TAG_W +: TAG_W] == req_tag) m[i] = 1'b1;
                else                                       c[i] = 1'b1;
            end
        end
        // The primary accepted last cycle is not yet visible in mshr_valid.
        aq_match = aq_v && aq_idx == req_idx && aq_tag == req_tag;
        aq_conf  = aq_v && aq_idx == req_idx && aq_tag != req_tag;
        stall    = (|c) | aq_match | aq_conf;
        hit      = |m;

        hit_sel = '0;
        for (int i = 0; i < NMSHR; i++) begin
            if (m[i]) hit_sel = PW'(i);
        end

        pri_sel   = '0;
        pri_found = 1'b0;
        for (int k = NMSHR - 1; k >= 0; k--) begin
            if (mshr_pri_rdy[alloc_ptr + PW'(k)]) begin
                pri_sel   = alloc_ptr + PW'(k);
                pri_found = 1'b1;
            end
        end

        req_ready = 1'b0;
        pri_val   = '0;
        sec_val   = '0;
        if (!stall) begin
            if (hit) begin
                req_ready        = mshr_sec_rdy[hit_sel];
                sec_val[hit_sel] = req_valid & mshr_sec_rdy[hit_sel];
            end else if (pri_found) begin
                req_ready        = 1'b1;
                pri_val[pri_sel] = req_valid;
            end
        end
        pri_fire   = |pri_val;
        alloc_full = ~|mshr_pri_rdy;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aq_v      <= 1'b0;
            aq_idx    <= '0;
            aq_tag    <= '0;
            alloc_ptr <= '0;
        end else begin
            aq_v <= pri_fire;
            if (pri_fire) begin
                aq_idx    <= req_idx;
                aq_tag    <= req_tag;
                alloc_ptr <= pri_sel + PW'(1);
            end
        end
    end

    rr_lock_arbiter #(.N(NMSHR)) u_mr_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (mr_req),
        .out_ready (meta_read_ready),
        .gnt       (mr_gnt),
        .valid     (meta_read_valid),
        .sel       (mr_sel),
        .lock      (mr_lock)
    );

    rr_lock_arbiter #(.N(NMSHR)) u_acq_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (acq_req),
        .out_ready (acquire_ready),
        .gnt       (acq_gnt),
        .valid     (acquire_valid),
        .sel       (acq_sel),
        .lock      (acq_lock)
    );

    a_single_match: assert property (@(posedge clock) disable iff (reset)
        req_valid |-> $onehot0(m));
    a_pri_sec_excl: assert property (@(posedge clock) disable iff (reset)
        !((|pri_val) && (|sec_val)));
    a_pri_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(pri_val) && $onehot0(sec_val));
endmodule

// File: doc/mshr_alloc_arbiter.md
MSHR_ALLOC_ARBITER -- requirements
Module: mshr_alloc_arbiter

Interface
REQ-001 SHALL have parameter NMSHR, default 4: number of MSHRs served (power of two, >=2).
REQ-002 SHALL have parameter IDX_W, default 6: set-index width.
REQ-003 SHALL have parameter TAG_W, default 20: tag width.
REQ-004 SHALL have ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  new miss request.
- req_ready  out  1  request accepted this cycle.
- req_idx  in  IDX_W  request set index.
- req_tag  in  TAG_W  request tag.
- mshr_valid  in  NMSHR  MSHR i holds a line (idx/tag valid).
- mshr_idx  in  NMSHR*IDX_W  packed MSHR indices.
- mshr_tag  in  NMSHR*TAG_W  packed MSHR tags.
- mshr_pri_rdy  in  NMSHR  MSHR i free for a primary.
- mshr_sec_rdy  in  NMSHR  MSHR i can merge a secondary.
- pri_val  out  NMSHR  one-hot primary issue.
- sec_val  out  NMSHR  one-hot secondary issue.
- mr_req  in  NMSHR  per-MSHR meta-read request.
- mr_gnt  out  NMSHR  one-hot meta-read ready back to MSHR.
- meta_read_valid  out  1  shared meta-read port valid.
- meta_read_ready  in  1  shared meta-read port ready.
- acq_req  in  NMSHR  per-MSHR acquire request.
- acq_gnt  out  NMSHR  one-hot acquire ready back to MSHR.
- acquire_valid  out  1  shared TileLink A-channel valid.
- acquire_ready  in  1  shared A-channel ready.
- acq_sel  out  log2(NMSHR)  MSHR owning current acquire (drives A-channel mux).
- alloc_full  out  1  no MSHR free for a primary.

Function
REQ-005 SHALL compute full match m[i] = mshr_valid[i] & idx equal & tag equal, and set conflict c[i] = mshr_valid[i] & idx equal & tag unequal.
REQ-006 SHALL set req_ready=0 when any c[i]=1 (set conflict stall).
REQ-007 SHALL, when m[i]=1, set req_ready=mshr_sec_rdy[i], sec_val[i]=req_valid & mshr_sec_rdy[i], pri_val=0.
REQ-008 SHALL, when no match and no conflict, select the first i with mshr_pri_rdy[i]=1 searching cyclically from alloc_ptr; req_ready=1 if any found; pri_val[i]=req_valid.
REQ-009 SHALL register the idx/tag of every accepted primary for one cycle (alloc_q) and treat alloc_q as an extra valid entry for REQ-005/006, so a same-block request next cycle stalls (req_ready=0).
REQ-010 SHALL advance alloc_ptr to (chosen+1) mod NMSHR on primary fire; pointer wraps NMSHR-1 -> 0.
REQ-011 SHALL drive alloc_full = ~|mshr_pri_rdy, combinationally.
REQ-012 SHALL arbitrate mr_req round-robin: meta_read_valid = |mr_req; winner = first requester at/after mr_ptr; mr_gnt[winner] = meta_read_ready.
REQ-013 SHALL lock the meta-read winner while meta_read_valid & ~meta_read_ready; a later higher-priority request does not preempt; lock clears on fire, mr_ptr <= winner+1.
REQ-014 SHALL arbitrate acq_req identically with independent acq_ptr and lock; acq_sel = current winner, stable while locked.
REQ-015 SHALL release a lock if the locked requester drops its request before fire (protocol error, flagged by assertion).
REQ-016 SHALL flag by assertion: more than one m[i], pri_val/sec_val both nonzero, non-one-hot grants.
REQ-017 SHALL have zero-cycle combinational request-to-grant latency; all state updates on clock rising edge.

Reset
REQ-018 SHALL on reset clear alloc_ptr, mr_ptr, acq_ptr to 0, both locks, and alloc_q valid; with zero inputs all outputs read 0 except alloc_full = 1.
REQ-019 SHALL abandon a locked grant on reset mid-operation; first post-reset arbitration starts from index 0.

Structure
REQ-020 SHALL take NMSHR, IDX_W, TAG_W defaults from the shared DCacheParams package; no local typedefs.
REQ-021 SHALL instantiate one sub-module rr_lock_arbiter (parameter N; req, out_ready, gnt, valid, sel, lock) twice: meta-read and acquire.

Verification
REQ-022 SHALL cover: all free, alloc_ptr=0, req idx=5 tag=0x123 -> pri_val=0001, next cycle same block -> req_ready=0 (alloc_q).
REQ-023 SHALL cover: MSHR2 holds idx=5 tag=0x123, sec_rdy[2]=1, same request -> sec_val=0100, req_ready=1; sec_rdy[2]=0 -> req_ready=0.
REQ-024 SHALL cover: MSHR1 holds idx=5 tag=0x7, request idx=5 tag=0x8 -> req_ready=0, pri_val=0.
REQ-025 SHALL cover: mr_req=1111, meta_read_ready=1 four cycles -> mr_gnt 0001,0010,0100,1000 then wrap 0001.
REQ-026 SHALL cover: acq_req=0010, acquire_ready=0 3 cycles, then acq_req=0011 -> acq_sel stays 1 until fire; next grant MSHR0.
REQ-027 SHALL cover: reset asserted while acquire locked on MSHR3 -> lock cleared, acq_ptr=0, next grant lowest requester.
